// File: rtl/avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_bus_arbiter
// Description : Shares the CPU's single Avalon-MM master port between the
//               instruction-fetch requester (r0) and the data load/store
//               requester (r1). Whole transactions are serialised, and the
//               slave's waitrequest/readdata are routed back to the owner.
//               An optional watchdog aborts a grant that the slave stalls
//               for too long.
// Ports       : clk, reset (async, active-low)
//               r0_* / r1_*  requester-side Avalon-MM slave ports
//               address/read/write/writedata/byteenable/waitrequest/readdata
//                            master-side Avalon-MM port
//               grant        one-hot owner (01 = r0, 10 = r1, 00 = idle)
//               bus_timeout  sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_bus_arbiter #(
    parameter int ROUND_ROBIN    = 1,   // 1: alternate on contention, 0: r1 always wins
    parameter int TIMEOUT_CYCLES = 0    // stalled-grant abort limit, 0 disables
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] r0_address,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [31:0] r0_writedata,
    input  logic [3:0]  r0_byteenable,
    output logic        r0_waitrequest,
    output logic [31:0] r0_readdata,
    input  logic [31:0] r1_address,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [31:0] r1_writedata,
    input  logic [3:0]  r1_byteenable,
    output logic        r1_waitrequest,
    output logic [31:0] r1_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  grant,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
    localparam logic        c_WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic        c_RR      = (ROUND_ROBIN != 0);

    state_t      state_q, state_d;
    logic        last_q, last_d;        // 0 = r0 served last, 1 = r1 served last
    logic [15:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;

    logic        w_req0, w_req1;
    logic        w_sel1;
    logic        w_sel_read, w_sel_write, w_sel_req;
    logic [31:0] w_sel_address, w_sel_writedata;
    logic [3:0]  w_sel_byteenable;
    logic        w_done;
    logic [31:0] w_rdata;
    logic        w_abort;

    assign w_req0 = r0_read | r0_write;
    assign w_req1 = r1_read | r1_write;

    // Mux of the owning requester's signals; only used while granted.
    assign w_sel1           = (state_q == S_GRANT1);
    assign w_sel_read       = w_sel1 ? r1_read       : r0_read;
    assign w_sel_write      = w_sel1 ? r1_write      : r0_write;
    assign w_sel_address    = w_sel1 ? r1_address    : r0_address;
    assign w_sel_writedata  = w_sel1 ? r1_writedata  : r0_writedata;
    assign w_sel_byteenable = w_sel1 ? r1_byteenable : r0_byteenable;
    assign w_sel_req        = w_sel_read | w_sel_write;

    // Abort fires in the cycle the stall counter has reached the limit.
    assign w_abort = c_WD_EN && (wdog_q == c_TIMEOUT);

    assign grant       = {state_q == S_GRANT1, state_q == S_GRANT0};
    assign bus_timeout = timeout_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        timeout_d  = timeout_q;
        address    = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
        byteenable = 4'd0;
        w_done     = 1'b0;
        w_rdata    = 32'd0;

        case (state_q)
            S_GRANT0, S_GRANT1: begin
                address    = w_sel_address;
                writedata  = w_sel_writedata;
                byteenable = w_sel_byteenable;
                write      = w_sel_write;
                // Simultaneous read+write is illegal; the write takes precedence.
                read       = w_sel_read & ~w_sel_write;
                if (!w_sel_req) begin
                    // Requester dropped out mid-transaction: release silently.
                    state_d = S_IDLE;
                    wdog_d  = 16'd0;
                end else if (w_abort) begin
                    w_done    = 1'b1;
                    w_rdata   = 32'hFFFF_FFFF;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    last_d    = w_sel1;
                    wdog_d    = 16'd0;
                end else if (!waitrequest) begin
                    w_done  = 1'b1;
                    w_rdata = readdata;
                    state_d = S_IDLE;
                    last_d  = w_sel1;
                    wdog_d  = 16'd0;
                end else if (wdog_q != 16'hFFFF) begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: begin
                wdog_d = 16'd0;
                if (w_req0 && w_req1) begin
                    state_d = (c_RR && last_q) ? S_GRANT0 : S_GRANT1;
                end else if (w_req0) begin
                    state_d = S_GRANT0;
                end else if (w_req1) begin
                    state_d = S_GRANT1;
                end
            end
        endcase

        r0_waitrequest = ~(w_done & ~w_sel1);
        r1_waitrequest = ~(w_done &  w_sel1);
        r0_readdata    = (w_done & ~w_sel1) ? w_rdata : 32'd0;
        r1_readdata    = (w_done &  w_sel1) ? w_rdata : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;   // first round-robin tie goes to r0
            wdog_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_bus_arbiter
// Description : Directed self-checking bench for avalon_bus_arbiter. Two
//               instances share stimulus: u_rr (round robin, 8-cycle
//               watchdog) and u_fp (fixed priority, watchdog disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] r0_address = '0, r1_address = '0;
    logic        r0_read = 1'b0, r0_write = 1'b0, r1_read = 1'b0, r1_write = 1'b0;
    logic [31:0] r0_writedata = '0, r1_writedata = '0;
    logic [3:0]  r0_byteenable = '0, r1_byteenable = '0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;

    logic        a_r0_wait, a_r1_wait, a_read, a_write, a_timeout;
    logic [31:0] a_r0_rdata, a_r1_rdata, a_address, a_writedata;
    logic [3:0]  a_be;
    logic [1:0]  a_grant;

    logic        b_r0_wait, b_r1_wait, b_read, b_write, b_timeout;
    logic [31:0] b_r0_rdata, b_r1_rdata, b_address, b_writedata;
    logic [3:0]  b_be;
    logic [1:0]  b_grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .reset(reset),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
        .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
        .r0_waitrequest(a_r0_wait), .r0_readdata(a_r0_rdata),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
        .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
        .r1_waitrequest(a_r1_wait), .r1_readdata(a_r1_rdata),
        .address(a_address), .read(a_read), .write(a_write),
        .writedata(a_writedata), .byteenable(a_be),
        .waitrequest(waitrequest), .readdata(readdata),
        .grant(a_grant), .bus_timeout(a_timeout)
    );

    avalon_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) u_fp (
        .clk(clk), .reset(reset),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
        .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
        .r0_waitrequest(b_r0_wait), .r0_readdata(b_r0_rdata),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
        .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
        .r1_waitrequest(b_r1_wait), .r1_readdata(b_r1_rdata),
        .address(b_address), .read(b_read), .write(b_write),
        .writedata(b_writedata), .byteenable(b_be),
        .waitrequest(waitrequest), .readdata(readdata),
        .grant(b_grant), .bus_timeout(b_timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        check_eq("rst_grant",   a_grant, 2'b00);
        check_eq("rst_strobes", {a_read, a_write}, 2'b00);
        check_eq("rst_waits",   {a_r1_wait, a_r0_wait}, 2'b11);
        check_eq("rst_rdata",   {a_r0_rdata, a_r1_rdata}, 64'd0);
        check_eq("rst_master",  {a_address, a_be}, 36'd0);
        check_eq("rst_timeout", a_timeout, 1'b0);
        reset = 1'b1;

        // ---------------- test 1: r0 read, slave completes in 2nd grant cycle
        nxt();
        r0_address = 32'hBFC0_0000; r0_read = 1'b1; waitrequest = 1'b1;
        #1;
        check_eq("t1_idle_grant", a_grant, 2'b00);
        check_eq("t1_idle_read",  a_read, 1'b0);
        nxt();
        #1;
        check_eq("t1_g1_grant", a_grant, 2'b01);
        check_eq("t1_g1_addr",  {a_read, a_address}, {1'b1, 32'hBFC0_0000});
        check_eq("t1_g1_wait",  a_r0_wait, 1'b1);
        nxt();
        waitrequest = 1'b0; readdata = 32'h1234_5678;
        #1;
        check_eq("t1_g2_grant", a_grant, 2'b01);
        check_eq("t1_g2_wait",  a_r0_wait, 1'b0);
        check_eq("t1_g2_rdata", a_r0_rdata, 32'h1234_5678);
        nxt();
        r0_read = 1'b0; r0_address = '0; readdata = '0;
        #1;
        check_eq("t1_after_grant", a_grant, 2'b00);
        check_eq("t1_after_wait",  a_r0_wait, 1'b1);

        // ---------------- test 3: r1 write with 3 stall cycles, r0 held off
        nxt();
        r1_address = 32'h0000_1000; r1_write = 1'b1; r1_writedata = 32'hDEAD_BEEF;
        r1_byteenable = 4'b0011; waitrequest = 1'b1;
        #1;
        check_eq("t3_idle_grant", a_grant, 2'b00);
        for (int c = 1; c <= 4; c++) begin
            nxt();
            r0_read = 1'b1; r0_address = 32'h0000_2000;
            waitrequest = (c == 4) ? 1'b0 : 1'b1;
            #1;
            check_eq($sformatf("t3_c%0d_master", c), {a_write, a_read, a_address, a_writedata, a_be},
                     {1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011});
            check_eq($sformatf("t3_c%0d_grant", c), a_grant, 2'b10);
            check_eq($sformatf("t3_c%0d_waits", c), {a_r1_wait, a_r0_wait},
                     (c == 4) ? 2'b01 : 2'b11);
        end
        nxt();
        r1_write = 1'b0; r1_writedata = '0; r1_byteenable = '0; r1_address = '0;
        #1;
        check_eq("t3_idle_gap", {a_grant, a_read, a_r0_wait}, {2'b00, 1'b0, 1'b1});
        nxt();
        readdata = 32'h0BAD_F00D;
        #1;
        check_eq("t3_r0_served", {a_grant, a_read, a_r0_wait}, {2'b01, 1'b1, 1'b0});
        check_eq("t3_r0_rdata",  a_r0_rdata, 32'h0BAD_F00D);
        nxt();
        r0_read = 1'b0; r0_address = '0; readdata = '0;

        // ---------------- test 4: watchdog abort after 8 stalled cycles
        nxt();
        r0_read = 1'b1; r0_address = 32'h0000_3000; waitrequest = 1'b1;
        for (int g = 1; g <= 9; g++) begin
            nxt();
            #1;
            if (g == 8) begin
                check_eq("t4_g8_wait",    a_r0_wait, 1'b1);
                check_eq("t4_g8_timeout", a_timeout, 1'b0);
            end
            if (g == 9) begin
                check_eq("t4_abort_wait",  a_r0_wait, 1'b0);
                check_eq("t4_abort_rdata", a_r0_rdata, 32'hFFFF_FFFF);
                check_eq("t4_abort_grant", a_grant, 2'b01);
            end
        end
        nxt();
        r0_read = 1'b0; waitrequest = 1'b0;
        #1;
        check_eq("t4_flag_set", {a_timeout, a_grant}, {1'b1, 2'b00});
        check_eq("t4_fp_no_flag", b_timeout, 1'b0);
        nxt();
        r0_read = 1'b1; readdata = 32'hA5A5_A5A5;
        nxt();
        #1;
        check_eq("t4_good_read", {a_r0_wait, a_r0_rdata}, {1'b0, 32'hA5A5_A5A5});
        check_eq("t4_flag_sticky", a_timeout, 1'b1);
        nxt();
        r0_read = 1'b0; r0_address = '0; readdata = '0;

        // ---------------- test 5: reset mid-GRANT1
        nxt();
        r1_read = 1'b1; r1_address = 32'h0000_4000; waitrequest = 1'b1;
        nxt();
        #1;
        check_eq("t5_granted", {a_grant, a_read}, {2'b10, 1'b1});
        #1 reset = 1'b0;
        #1;
        check_eq("t5_async_drop", {a_grant, a_read, a_write}, {2'b00, 1'b0, 1'b0});
        check_eq("t5_async_flag", a_timeout, 1'b0);
        nxt();
        check_eq("t5_in_reset", a_grant, 2'b00);
        #1 reset = 1'b1;
        nxt();
        waitrequest = 1'b0; readdata = 32'h5555_AAAA;
        #1;
        check_eq("t5_regrant", {a_grant, a_read, a_r1_wait}, {2'b10, 1'b1, 1'b0});
        check_eq("t5_rdata",   a_r1_rdata, 32'h5555_AAAA);
        nxt();
        r1_read = 1'b0; r1_address = '0; readdata = '0;

        // ---------------- tests 2/6: both requesting continuously from reset
        nxt();
        reset = 1'b0;
        r0_read = 1'b1; r0_write = 1'b1;     // illegal combo: write must win
        r1_read = 1'b1; waitrequest = 1'b0;
        nxt();
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            logic [1:0] ga, gb, rw;
            #1;
            if (k % 2 == 0) ga = 2'b00;
            else            ga = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            gb = (k % 2 == 0) ? 2'b00 : 2'b10;
            rw = (ga == 2'b01) ? 2'b01 : ((ga == 2'b10) ? 2'b10 : 2'b00);
            check_eq($sformatf("rr_k%0d", k),
                     {a_grant, a_read, a_write, a_r1_wait, a_r0_wait},
                     {ga, rw, ga != 2'b10, ga != 2'b01});
            check_eq($sformatf("fp_k%0d", k), b_grant, gb);
            nxt();
        end
        r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
